lo_sequencer: RTL

- Controller that generates and sequences the quadrature LO drive for the double-balanced mixer: programmable integer divide of clk into 4-phase I/Q square waves.
- Accepts tuning/enable commands over a valid/ready config handshake.
- Applies a new divisor only at an LO cycle boundary, so the I/Q outputs never produce runt pulses.
- Gates the IF path through mix_en during retune/settle windows; sits between host config logic and the mixer LO input.

---
 rtl/lo_sequencer_if.sv | 24 ++
 rtl/lo_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lo_sequencer_if.sv
// Config handshake between host tuning logic and the LO sequencer.
// A command transfers on a rising clock edge when cfg_valid && cfg_ready.
interface lo_sequencer_if #(
  parameter int unsigned DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_en,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_en,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/lo_sequencer.sv
// Quadrature LO sequencer: divides clk into 4-phase I/Q square waves and only retunes
// at LO period boundaries, gating the IF path (mix_en) while settling.
module lo_sequencer #(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SET_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  lo_sequencer_if.slave  cfg,
  output logic           lo_i,
  output logic           lo_q,
  output logic           mix_en,
  output logic           busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StRun,
    StPend
  } state_e;

  localparam logic [SET_W-1:0] SettleLast = SET_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] qcnt_q, qcnt_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_en_q, pend_en_d;
  logic [1:0]       phase_q, phase_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             lo_i_q, lo_i_d;
  logic             lo_q_q, lo_q_d;
  logic             mix_en_q, mix_en_d;
  logic             busy_q, busy_d;

  logic running;
  logic accept;
  logic tc;
  logic boundary;

  assign running   = (state_q != StIdle);
  assign cfg.cfg_ready = (state_q == StIdle) || (state_q == StRun);
  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign tc        = (qcnt_q == div_q);
  // Last clk of an LO period: the only point where a divisor change cannot cut a pulse.
  assign boundary  = tc && (phase_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_en_d  = pend_en_q;
    settle_d   = settle_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;

    if (running) begin
      if (tc) begin
        qcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        qcnt_d  = qcnt_q + DIV_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        qcnt_d   = '0;
        phase_d  = '0;
        settle_d = '0;
        if (accept && cfg.cfg_en) begin
          div_d   = cfg.cfg_div;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StRun;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      StRun: begin
        if (accept) begin
          pend_div_d = cfg.cfg_div;
          pend_en_d  = cfg.cfg_en;
          state_d    = StPend;
        end
      end
      StPend: begin
        if (boundary) begin
          qcnt_d  = '0;
          phase_d = '0;
          if (pend_en_q) begin
            div_d    = pend_div_q;
            settle_d = '0;
            state_d  = StSettle;
          end else begin
            state_d  = StIdle;
          end
        end
      end
    endcase

    // Phase map I = 1,1,0,0 and Q = 0,1,1,0, so Q lags I by a quarter period.
    lo_i_d   = running && (phase_q < 2'd2);
    lo_q_d   = running && ((phase_q == 2'd1) || (phase_q == 2'd2));
    mix_en_d = (state_d == StRun);
    busy_d   = (state_d == StSettle) || (state_d == StPend);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      pend_div_q <= '0;
      pend_en_q  <= 1'b0;
      settle_q   <= '0;
      qcnt_q     <= '0;
      phase_q    <= '0;
      lo_i_q     <= 1'b0;
      lo_q_q     <= 1'b0;
      mix_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_en_q  <= pend_en_d;
      settle_q   <= settle_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      lo_i_q     <= lo_i_d;
      lo_q_q     <= lo_q_d;
      mix_en_q   <= mix_en_d;
      busy_q     <= busy_d;
    end
  end

  assign lo_i   = lo_i_q;
  assign lo_q   = lo_q_q;
  assign mix_en = mix_en_q;
  assign busy   = busy_q;

`ifndef SYNTHESIS
  mix_busy_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(mix_en_q && busy_q));
  qcnt_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    qcnt_q <= div_q);
  idle_quiet_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle) |-> ((qcnt_q == '0) && (phase_q == 2'd0)));
`endif

endmodule
